// File: rtl/leaf_bridge_pkg.sv
// Shared definitions for the leaf port bridge.
// Contents:
//   DEF_FIFO_DEPTH / DEF_STALL_CNT  default channel depth and stall threshold
//   BUS_MAX                         widest flat data bus slice_chan can index
//   calc_ptr_bits(depth)            PTR_BITS = clog2(FIFO_DEPTH)
//   calc_run_bits(stall_cnt)        RUN_BITS = clog2(STALL_CNT+1)
//   sat_inc(value, bits)            +1 that sticks at 2^bits-1 (bits <= 64)
//   slice_chan(bus, idx, width)     channel idx of a flat bus, in the low bits
package leaf_bridge_pkg;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_STALL_CNT  = 1;
  localparam int BUS_MAX        = 4096;

  function automatic int calc_ptr_bits(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int calc_run_bits(input int stall_cnt);
    int b;
    b = $clog2(stall_cnt + 1);
    return (b < 1) ? 1 : b;
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int bits);
    logic [63:0] max_val;
    max_val = (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
    return (value >= max_val) ? max_val : value + 64'd1;
  endfunction

  // Callers truncate the result to their channel width.
  function automatic logic [BUS_MAX-1:0] slice_chan(input logic [BUS_MAX-1:0] bus,
                                                    input int idx, input int width);
    return bus >> (idx * width);
  endfunction

endpackage

// File: rtl/leaf_chan_fifo.sv
// One bridge channel: decoupling FIFO, full/empty/read counters, stall flag.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   soft_clr          synchronous clear, beats any same-cycle push/pop
//   cnt_en            counters advance only when 1
//   pop_block         holds the head word and drops vld_out (resend gating)
//   din/vld_in/ack_in producer side; ack_in = not full
//   dout/vld_out/rdy_out consumer side; vld_out = not empty and not blocked
//   full_cnt, empty_cnt, read_cnt  saturating performance counters
//   stall             registered stall_condition flag
// Handshake: a word moves on a rising edge where the sender's valid and the
// receiver's ready/ack are both 1; valid never depends on ready in this block,
// and a pushed word is first visible at the consumer one cycle later.
module leaf_chan_fifo
  import leaf_bridge_pkg::*;
#(
  parameter int PAYLOAD_BITS = 32,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int CNT_BITS     = 32,
  parameter int STALL_CNT    = DEF_STALL_CNT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    soft_clr,
  input  logic                    cnt_en,
  input  logic                    pop_block,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    vld_in,
  output logic                    ack_in,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    vld_out,
  input  logic                    rdy_out,
  output logic [CNT_BITS-1:0]     full_cnt,
  output logic [CNT_BITS-1:0]     empty_cnt,
  output logic [CNT_BITS-1:0]     read_cnt,
  output logic                    stall
);

  localparam int PTR_BITS = calc_ptr_bits(FIFO_DEPTH);
  localparam int RUN_BITS = calc_run_bits(STALL_CNT);
  localparam logic [PTR_BITS:0]   OCC_FULL = (PTR_BITS + 1)'(FIFO_DEPTH);
  localparam logic [RUN_BITS-1:0] STALL_TH = RUN_BITS'(STALL_CNT);

  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]     rptr;
  logic [PTR_BITS-1:0]     wptr;
  logic [PTR_BITS:0]       occ;
  logic [RUN_BITS-1:0]     run;
  logic [RUN_BITS-1:0]     run_next;
  logic full, empty, push, pop, full_hit, empty_hit;

  assign full    = (occ == OCC_FULL);
  assign empty   = (occ == '0);
  // ack drops on full even if a pop happens this cycle: no full-to-full push.
  assign ack_in  = ~full;
  assign vld_out = ~empty & ~pop_block;
  assign dout    = empty ? '0 : mem[rptr];
  assign push    = vld_in & ~full;
  assign pop     = vld_out & rdy_out;

  // A blocked cycle with data present is neither a full nor an empty event.
  assign full_hit  = vld_in & full & ~pop_block;
  assign empty_hit = rdy_out & empty;
  assign run_next  = full_hit ? RUN_BITS'(sat_inc(64'(run), RUN_BITS)) : '0;

  always_ff @(posedge clk) begin
    if (push && !soft_clr) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      occ  <= '0;
    end else if (soft_clr) begin
      rptr <= '0;
      wptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_BITS'(1);
      if (pop)  rptr <= rptr + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_BITS + 1)'(1);
        2'b01:   occ <= occ - (PTR_BITS + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_cnt  <= '0;
      empty_cnt <= '0;
      read_cnt  <= '0;
      run       <= '0;
      stall     <= 1'b0;
    end else if (soft_clr) begin
      full_cnt  <= '0;
      empty_cnt <= '0;
      read_cnt  <= '0;
      run       <= '0;
      stall     <= 1'b0;
    end else begin
      if (cnt_en && full_hit)  full_cnt  <= CNT_BITS'(sat_inc(64'(full_cnt), CNT_BITS));
      if (cnt_en && empty_hit) empty_cnt <= CNT_BITS'(sat_inc(64'(empty_cnt), CNT_BITS));
      if (cnt_en && pop)       read_cnt  <= CNT_BITS'(sat_inc(64'(read_cnt), CNT_BITS));
      // The run length ignores cnt_en; the flag tracks it with no extra delay.
      run   <= run_next;
      stall <= (run_next >= STALL_TH);
    end
  end

endmodule

// File: rtl/leaf_port_bridge.sv
// Stream bridge between the leaf interface port cluster and an HLS kernel.
// Input channels (interface -> kernel) and output channels (kernel ->
// interface) each get one leaf_chan_fifo. resend blocks only the pop side of
// output channels, so interface-bound traffic stalls while the kernel may
// keep filling its FIFOs.
// Ports:
//   ap_clk, ap_rst_n             user clock, asynchronous active-low reset
//   soft_clr, cnt_en, resend     clear, counter enable, interface-bound hold
//   din_if/vld_if/ack_if         interface -> bridge (input channels)
//   dout_user/vld_user/ack_user  bridge -> kernel (input channels)
//   din_user/vld_user_out/ack_user_out  kernel -> bridge (output channels)
//   dout_if/vld_if_out/ack_if_out       bridge -> interface (output channels)
//   *_cnt_in / *_cnt_out         per-channel counters, channel i at i*CNT_BITS
//   stall_in / stall_out         per-channel stall_condition flags
// Flat data buses carry channel i at [i*PAYLOAD_BITS +: PAYLOAD_BITS] and must
// not exceed BUS_MAX bits.
module leaf_port_bridge
  import leaf_bridge_pkg::*;
#(
  parameter int NUM_IN_PORTS  = 1,
  parameter int NUM_OUT_PORTS = 1,
  parameter int PAYLOAD_BITS  = 32,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int CNT_BITS      = 32,
  parameter int STALL_CNT     = DEF_STALL_CNT
) (
  input  logic                                   ap_clk,
  input  logic                                   ap_rst_n,
  input  logic                                   soft_clr,
  input  logic                                   cnt_en,
  input  logic                                   resend,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]   din_if,
  input  logic [NUM_IN_PORTS-1:0]                vld_if,
  output logic [NUM_IN_PORTS-1:0]                ack_if,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]   dout_user,
  output logic [NUM_IN_PORTS-1:0]                vld_user,
  input  logic [NUM_IN_PORTS-1:0]                ack_user,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_user,
  input  logic [NUM_OUT_PORTS-1:0]               vld_user_out,
  output logic [NUM_OUT_PORTS-1:0]               ack_user_out,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  dout_if,
  output logic [NUM_OUT_PORTS-1:0]               vld_if_out,
  input  logic [NUM_OUT_PORTS-1:0]               ack_if_out,
  output logic [NUM_IN_PORTS*CNT_BITS-1:0]       full_cnt_in,
  output logic [NUM_IN_PORTS*CNT_BITS-1:0]       empty_cnt_in,
  output logic [NUM_IN_PORTS*CNT_BITS-1:0]       read_cnt_in,
  output logic [NUM_OUT_PORTS*CNT_BITS-1:0]      full_cnt_out,
  output logic [NUM_OUT_PORTS*CNT_BITS-1:0]      empty_cnt_out,
  output logic [NUM_OUT_PORTS*CNT_BITS-1:0]      read_cnt_out,
  output logic [NUM_IN_PORTS-1:0]                stall_in,
  output logic [NUM_OUT_PORTS-1:0]               stall_out
);

  genvar i;

  for (i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    leaf_chan_fifo #(
      .PAYLOAD_BITS(PAYLOAD_BITS), .FIFO_DEPTH(FIFO_DEPTH),
      .CNT_BITS(CNT_BITS), .STALL_CNT(STALL_CNT)
    ) u_chan (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .soft_clr  (soft_clr),
      .cnt_en    (cnt_en),
      .pop_block (1'b0),
      .din       (PAYLOAD_BITS'(slice_chan(BUS_MAX'(din_if), i, PAYLOAD_BITS))),
      .vld_in    (vld_if[i]),
      .ack_in    (ack_if[i]),
      .dout      (dout_user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .vld_out   (vld_user[i]),
      .rdy_out   (ack_user[i]),
      .full_cnt  (full_cnt_in[i*CNT_BITS +: CNT_BITS]),
      .empty_cnt (empty_cnt_in[i*CNT_BITS +: CNT_BITS]),
      .read_cnt  (read_cnt_in[i*CNT_BITS +: CNT_BITS]),
      .stall     (stall_in[i])
    );
  end

  for (i = 0; i < NUM_OUT_PORTS; i++) begin : g_out
    leaf_chan_fifo #(
      .PAYLOAD_BITS(PAYLOAD_BITS), .FIFO_DEPTH(FIFO_DEPTH),
      .CNT_BITS(CNT_BITS), .STALL_CNT(STALL_CNT)
    ) u_chan (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .soft_clr  (soft_clr),
      .cnt_en    (cnt_en),
      .pop_block (resend),
      .din       (PAYLOAD_BITS'(slice_chan(BUS_MAX'(din_user), i, PAYLOAD_BITS))),
      .vld_in    (vld_user_out[i]),
      .ack_in    (ack_user_out[i]),
      .dout      (dout_if[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .vld_out   (vld_if_out[i]),
      .rdy_out   (ack_if_out[i]),
      .full_cnt  (full_cnt_out[i*CNT_BITS +: CNT_BITS]),
      .empty_cnt (empty_cnt_out[i*CNT_BITS +: CNT_BITS]),
      .read_cnt  (read_cnt_out[i*CNT_BITS +: CNT_BITS]),
      .stall     (stall_out[i])
    );
  end

endmodule

// File: tb/tb_leaf_port_bridge.sv
// Bench for leaf_port_bridge with 3 input and 2 output channels.
// Inputs change 1 time unit after the rising edge; the reference model and
// the monitor look at the DUT on the falling edge.
module tb_leaf_port_bridge;

  localparam int NI   = 3;
  localparam int NO   = 2;
  localparam int NC   = NI + NO;
  localparam int PW   = 32;
  localparam int D    = 4;
  localparam int CB   = 8;
  localparam int SC   = 1;
  localparam int CMAX = (1 << CB) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic ap_clk = 1'b0;
  logic ap_rst_n, soft_clr, cnt_en, resend;
  logic [NI*PW-1:0] din_if, dout_user;
  logic [NI-1:0]    vld_if, ack_if, vld_user, ack_user, stall_in;
  logic [NO*PW-1:0] din_user, dout_if;
  logic [NO-1:0]    vld_user_out, ack_user_out, vld_if_out, ack_if_out, stall_out;
  logic [NI*CB-1:0] full_cnt_in, empty_cnt_in, read_cnt_in;
  logic [NO*CB-1:0] full_cnt_out, empty_cnt_out, read_cnt_out;

  always #5 ap_clk = ~ap_clk;

  leaf_port_bridge #(
    .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .PAYLOAD_BITS(PW),
    .FIFO_DEPTH(D), .CNT_BITS(CB), .STALL_CNT(SC)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .soft_clr(soft_clr), .cnt_en(cnt_en),
    .resend(resend), .din_if(din_if), .vld_if(vld_if), .ack_if(ack_if),
    .dout_user(dout_user), .vld_user(vld_user), .ack_user(ack_user),
    .din_user(din_user), .vld_user_out(vld_user_out), .ack_user_out(ack_user_out),
    .dout_if(dout_if), .vld_if_out(vld_if_out), .ack_if_out(ack_if_out),
    .full_cnt_in(full_cnt_in), .empty_cnt_in(empty_cnt_in), .read_cnt_in(read_cnt_in),
    .full_cnt_out(full_cnt_out), .empty_cnt_out(empty_cnt_out), .read_cnt_out(read_cnt_out),
    .stall_in(stall_in), .stall_out(stall_out)
  );

  // Uniform per-channel view: channels 0..NI-1 are inputs, NI.. are outputs.
  logic          c_vin [NC];
  logic          c_ack [NC];
  logic          c_vout[NC];
  logic          c_rdy [NC];
  logic          c_stl [NC];
  logic [PW-1:0] c_din [NC];
  logic [PW-1:0] c_dout[NC];
  logic [CB-1:0] c_full[NC];
  logic [CB-1:0] c_emp [NC];
  logic [CB-1:0] c_read[NC];

  always_comb begin
    for (int c = 0; c < NI; c++) begin
      c_vin[c]  = vld_if[c];
      c_ack[c]  = ack_if[c];
      c_vout[c] = vld_user[c];
      c_rdy[c]  = ack_user[c];
      c_stl[c]  = stall_in[c];
      c_din[c]  = din_if[c*PW +: PW];
      c_dout[c] = dout_user[c*PW +: PW];
      c_full[c] = full_cnt_in[c*CB +: CB];
      c_emp[c]  = empty_cnt_in[c*CB +: CB];
      c_read[c] = read_cnt_in[c*CB +: CB];
    end
    for (int c = 0; c < NO; c++) begin
      c_vin[NI+c]  = vld_user_out[c];
      c_ack[NI+c]  = ack_user_out[c];
      c_vout[NI+c] = vld_if_out[c];
      c_rdy[NI+c]  = ack_if_out[c];
      c_stl[NI+c]  = stall_out[c];
      c_din[NI+c]  = din_user[c*PW +: PW];
      c_dout[NI+c] = dout_if[c*PW +: PW];
      c_full[NI+c] = full_cnt_out[c*CB +: CB];
      c_emp[NI+c]  = empty_cnt_out[c*CB +: CB];
      c_read[NI+c] = read_cnt_out[c*CB +: CB];
    end
  end

  // ---------------- scoreboard state / reference model ----------------
  int total = 0;
  int bad   = 0;
  logic [PW-1:0] exp_q [NC][$];
  int m_full[NC], m_empty[NC], m_read[NC], m_run[NC];
  bit m_stall[NC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      exp_q[c].delete();
      m_full[c] = 0; m_empty[c] = 0; m_read[c] = 0; m_run[c] = 0; m_stall[c] = 1'b0;
    end
  endtask

  function automatic bit any_pending();
    for (int c = 0; c < NC; c++) if (exp_q[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Model: FIFO contents are the expected queues; counters follow the rules.
  always @(negedge ap_clk) begin
    int  sz;
    bit  blk, mfull, mempty, mpop, hit;
    if (!ap_rst_n) model_clear();
    for (int c = 0; c < NC; c++) begin
      sz  = exp_q[c].size();
      blk = (c >= NI) && resend;
      chk($sformatf("ack ch%0d", c), 64'(c_ack[c]), 64'(sz != D));
      chk($sformatf("vld ch%0d", c), 64'(c_vout[c]), 64'((sz > 0) && !blk));
      if (sz == 0) chk($sformatf("idle data ch%0d", c), 64'(c_dout[c]), 64'd0);
      chk($sformatf("full_cnt ch%0d", c), 64'(c_full[c]), 64'(m_full[c]));
      chk($sformatf("empty_cnt ch%0d", c), 64'(c_emp[c]), 64'(m_empty[c]));
      chk($sformatf("read_cnt ch%0d", c), 64'(c_read[c]), 64'(m_read[c]));
      chk($sformatf("stall ch%0d", c), 64'(c_stl[c]), 64'(m_stall[c]));
    end
    if (ap_rst_n) begin
      if (soft_clr) model_clear();
      else begin
        for (int c = 0; c < NC; c++) begin
          sz     = exp_q[c].size();
          blk    = (c >= NI) && resend;
          mfull  = (sz == D);
          mempty = (sz == 0);
          mpop   = !mempty && !blk && c_rdy[c];
          hit    = c_vin[c] && mfull && !blk;
          if (cnt_en) begin
            if (hit && m_full[c] < CMAX) m_full[c]++;
            if (c_rdy[c] && mempty && m_empty[c] < CMAX) m_empty[c]++;
            if (mpop && m_read[c] < CMAX) m_read[c]++;
          end
          m_run[c]   = hit ? m_run[c] + 1 : 0;
          m_stall[c] = (m_run[c] >= SC);
          if (c_vin[c] && !mfull) exp_q[c].push_back(c_din[c]);
        end
      end
    end
  end

  // Monitor: every word the DUT hands over is compared with the queue head.
  always @(negedge ap_clk) begin
    logic [PW-1:0] e;
    #1;
    if (ap_rst_n && !soft_clr) begin
      for (int c = 0; c < NC; c++) begin
        if (c_vout[c] && c_rdy[c]) begin
          if (exp_q[c].size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra word ch%0d: got %0h expected none", c, c_dout[c]);
          end else begin
            e = exp_q[c].pop_front();
            chk($sformatf("data ch%0d", c), 64'(c_dout[c]), 64'(e));
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic clr_pulse();
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
  endtask

  task automatic idle_inputs();
    vld_if = '0; vld_user_out = '0; ack_user = '1; ack_if_out = '1;
    resend = 1'b0; cnt_en = 1'b1; soft_clr = 1'b0;
  endtask

  initial begin
    int n, guard;
    bit acc;
    ap_rst_n = 1'b0; din_if = '0; din_user = '0;
    idle_inputs();
    repeat (2) tick();
    ap_rst_n = 1'b1;

    // Single word through input channel 0.
    clr_pulse();
    din_if[0 +: PW] = 32'hDEADBEEF;
    vld_if[0] = 1'b1;
    tick();
    vld_if[0] = 1'b0;
    repeat (2) tick();
    @(negedge ap_clk);
    chk("single read_cnt_in", 64'(read_cnt_in[0 +: CB]), 64'd1);

    // Full boundary on channel 1 while channels 0 and 2 stream freely.
    @(posedge ap_clk); #1;
    clr_pulse();
    ack_user = 3'b101;
    vld_if   = 3'b111;
    for (int k = 0; k < 6; k++) begin
      din_if = {$urandom, $urandom, $urandom};
      tick();
    end
    vld_if = '0;
    @(negedge ap_clk);
    chk("boundary full_cnt ch1", 64'(full_cnt_in[CB +: CB]), 64'd2);
    chk("boundary stall ch1", 64'(stall_in[1]), 64'd1);
    chk("boundary full_cnt ch0", 64'(full_cnt_in[0 +: CB]), 64'd0);
    @(posedge ap_clk); #1;
    ack_user = '1;
    repeat (6) tick();

    // Wrap-around: 0..99 through channel 0 with random back-pressure.
    clr_pulse();
    n = 0;
    guard = 0;
    while (n < 100 && guard < 3000) begin
      din_if[0 +: PW] = PW'(n);
      vld_if[0]   = ($urandom_range(0, 3) != 0);
      ack_user[0] = ($urandom_range(0, 1) != 0);
      @(negedge ap_clk);
      acc = vld_if[0] && ack_if[0];
      @(posedge ap_clk); #1;
      if (acc) n++;
      guard++;
    end
    chk("wrap words sent", 64'(n), 64'd100);
    vld_if = '0;
    ack_user = '1;
    repeat (8) tick();
    @(negedge ap_clk);
    chk("wrap read_cnt_in", 64'(read_cnt_in[0 +: CB]), 64'd100);

    // Resend holds three words in output channel 0.
    @(posedge ap_clk); #1;
    clr_pulse();
    ack_if_out[0] = 1'b0;
    vld_user_out[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din_user[0 +: PW] = 32'hA000 + 32'(k);
      tick();
    end
    vld_user_out[0] = 1'b0;
    resend = 1'b1;
    ack_if_out = '1;
    repeat (5) tick();
    @(negedge ap_clk);
    chk("resend read_cnt_out", 64'(read_cnt_out[0 +: CB]), 64'd0);
    chk("resend empty_cnt_out", 64'(empty_cnt_out[0 +: CB]), 64'd0);
    @(posedge ap_clk); #1;
    resend = 1'b0;
    repeat (5) tick();
    @(negedge ap_clk);
    chk("resend drained read_cnt_out", 64'(read_cnt_out[0 +: CB]), 64'd3);
    @(posedge ap_clk); #1;

    // Random traffic on every channel, with occasional clears and resend.
    for (int k = 0; k < 400; k++) begin
      soft_clr     = ($urandom_range(0, 49) == 0);
      cnt_en       = ($urandom_range(0, 7) != 0);
      resend       = ($urandom_range(0, 3) == 0);
      vld_if       = NI'($urandom);
      ack_user     = NI'($urandom);
      vld_user_out = NO'($urandom);
      ack_if_out   = NO'($urandom);
      din_if       = {$urandom, $urandom, $urandom};
      din_user     = {$urandom, $urandom};
      tick();
    end
    idle_inputs();
    repeat (8) tick();

    // Saturation of the empty counters, then soft_clr together with a push.
    clr_pulse();
    repeat (300) tick();
    @(negedge ap_clk);
    chk("sat empty_cnt_in ch0", 64'(empty_cnt_in[0 +: CB]), 64'(CMAX));
    chk("sat empty_cnt_out ch1", 64'(empty_cnt_out[CB +: CB]), 64'(CMAX));
    @(posedge ap_clk); #1;
    soft_clr = 1'b1;
    vld_if[0] = 1'b1;
    din_if[0 +: PW] = $urandom;
    tick();
    soft_clr = 1'b0;
    vld_if = '0;
    @(negedge ap_clk);
    chk("clr vld_user", 64'(vld_user), 64'd0);
    chk("clr empty_cnt_in", 64'(empty_cnt_in), 64'd0);
    @(posedge ap_clk); #1;

    // Asynchronous reset in the middle of traffic.
    ack_user = '0;
    vld_if = '1;
    vld_user_out = '1;
    for (int k = 0; k < 3; k++) begin
      din_if = {$urandom, $urandom, $urandom};
      din_user = {$urandom, $urandom};
      tick();
    end
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    chk("rst ack_if", 64'(ack_if), 64'(3'b111));
    chk("rst vld_user", 64'(vld_user), 64'd0);
    chk("rst dout_user", 64'(dout_user), 64'd0);
    chk("rst read_cnt_in", 64'(read_cnt_in), 64'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    idle_inputs();

    // Drain whatever is left, bounded.
    guard = 0;
    while (any_pending() && guard < 50) begin
      tick();
      guard++;
    end
    chk("drain queues empty", 64'(any_pending()), 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leaf_port_bridge.md
Name: leaf_port_bridge

Overview:
- Parametrised stream bridge between a leaf_interface_* user-side port cluster and an HLS user kernel.
- Supports NUM_IN_PORTS/NUM_OUT_PORTS channels, each with a small decoupling FIFO.
- Collects per-channel full/empty/read stall counters and stall_condition flags.
- Gates interface-bound traffic during resend.
- Sits inside leafN wrappers in the user clock domain.

Parameters:
- NUM_IN_PORTS, 1, channels interface->user.
- NUM_OUT_PORTS, 1, channels user->interface.
- PAYLOAD_BITS, 32, data width per channel.
- FIFO_DEPTH, 4, entries per channel FIFO; power of 2, >=2.
- CNT_BITS, 32, width of each perf counter.
- STALL_CNT, 1, consecutive blocked cycles before stall_condition asserts; >=1.

Ports:
- ap_clk  in  1  user clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- soft_clr  in  1  synchronous clear of FIFOs, counters and flags.
- cnt_en  in  1  counters advance only when 1.
- resend  in  1  blocks all transfers toward interface.
- din_if  in  NUM_IN_PORTS*PAYLOAD_BITS  interface->bridge data, channel i at [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_if  in  NUM_IN_PORTS  interface data valid.
- ack_if  out  NUM_IN_PORTS  bridge ready to interface.
- dout_user  out  NUM_IN_PORTS*PAYLOAD_BITS  to kernel Input_i_TDATA.
- vld_user  out  NUM_IN_PORTS  TVALID to kernel.
- ack_user  in  NUM_IN_PORTS  kernel TREADY.
- din_user  in  NUM_OUT_PORTS*PAYLOAD_BITS  kernel Output_i_TDATA.
- vld_user_out  in  NUM_OUT_PORTS  kernel TVALID.
- ack_user_out  out  NUM_OUT_PORTS  TREADY to kernel.
- dout_if  out  NUM_OUT_PORTS*PAYLOAD_BITS  bridge->interface data.
- vld_if_out  out  NUM_OUT_PORTS  valid to interface.
- ack_if_out  in  NUM_OUT_PORTS  interface ready.
- full_cnt_in, empty_cnt_in, read_cnt_in  out  NUM_IN_PORTS*CNT_BITS  input-channel counters.
- full_cnt_out, empty_cnt_out, read_cnt_out  out  NUM_OUT_PORTS*CNT_BITS  output-channel counters.
- stall_in  out  NUM_IN_PORTS  input stall_condition flags.
- stall_out  out  NUM_OUT_PORTS  output stall_condition flags.

Behaviour:
- Reset: every FIFO is empty, all counters are 0, all stall flags are 0, all vld outputs are 0. ack outputs are 1; ack_if/ack_user_out are not gated by resend. Data outputs are 0.
- soft_clr has the same effect as reset, applied synchronously, and has priority over any same-cycle push or pop.
- Channel FIFO:
  - Push when the producer's valid is 1 and its ack (= not full) is 1.
  - Pop when the consumer's valid (= not empty) is 1 and its ready is 1.
  - Latency: a word pushed in cycle t is visible at the consumer in t+1. There is no combinational pass-through.
  - Full: ack=0 even if a pop occurs in the same cycle, so no full-to-full push.
  - Simultaneous push and pop when not full and not empty: occupancy is unchanged.
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Occupancy is a separate counter, 0..FIFO_DEPTH.
  - Data is ordered strictly FIFO per channel. There is no cross-channel ordering.
- resend=1: vld_if_out is forced to 0 and no output-FIFO pop occurs; head data is held. Input channels and kernel-side push are unaffected. Traffic resumes the cycle after resend falls.
- Counters, all saturating at 2^CNT_BITS-1, advancing only when cnt_en=1:
  - full_cnt: +1 per cycle when the producer's valid=1 and the FIFO is full.
  - empty_cnt: +1 per cycle when the consumer's ready=1 and the FIFO is empty.
  - read_cnt: +1 per pop.
  - For output channels, a resend-blocked cycle with data present counts toward neither full_cnt nor empty_cnt.
- stall_condition:
  - A per-channel run counter of width clog2(STALL_CNT+1) increments (saturating) each cycle where full_cnt's increment condition holds, regardless of cnt_en; otherwise it resets to 0.
  - The flag is registered: 1 when run >= STALL_CNT. It clears the cycle after the condition drops.

Decomposition:
- Package leaf_bridge_pkg holds:
  - PTR_BITS = clog2(FIFO_DEPTH).
  - RUN_BITS.
  - the saturating-increment function.
  - a function to slice channel i from a flat bus.
- Natural sub-module: leaf_chan_fifo, holding one channel's FIFO, the three counters and the stall flag.
  - It has a pop_block input, tied to resend for output channels and to 0 for input channels.
  - It is instantiated via generate per channel in both directions.

Test Plan:
- Single word: reset, NUM_IN=1, push 0xDEADBEEF at t0 with ack_user=1 -> vld_user=1 at t1 with data 0xDEADBEEF; read_cnt_in=1 after t1.
- Full boundary: FIFO_DEPTH=4, ack_user=0, vld_if held 1 for 6 cycles -> 4 accepted, ack_if=0 from cycle 4; full_cnt_in=2; with STALL_CNT=1, stall_in=1 one cycle after the first blocked cycle.
- Wrap-around: stream 0..99 through the channel with random ack_user -> output 0..99 in order; read_cnt_in=100; no loss or duplication.
- Resend: output FIFO holds 3 words, resend=1 for 5 cycles with ack_if_out=1 -> vld_if_out=0 throughout and the counters are unchanged; after release, 3 words arrive in order.
- Multi-channel: NUM_IN=3, NUM_OUT=2; stall only channel 1 -> only that channel's counters and flag move; other channels run at full rate.
- Saturation and clear: CNT_BITS=4, 20 empty cycles -> empty_cnt=15; soft_clr mid-stream together with a push -> FIFO empty and all counters 0 next cycle; ap_rst_n pulsed low mid-transfer -> immediate reset values.
